// File: rtl/gate_truth_sweeper_pkg.sv
// Shared encodings for the gate truth sweeper: mode codes, FSM states and
// the mode sanitiser applied when a sweep request is latched.
package gate_sweep_pkg;

   localparam logic [2:0] MODE_AND  = 3'd0;
   localparam logic [2:0] MODE_OR   = 3'd1;
   localparam logic [2:0] MODE_NAND = 3'd2;
   localparam logic [2:0] MODE_NOR  = 3'd3;
   localparam logic [2:0] MODE_XOR  = 3'd4;
   localparam logic [2:0] MODE_XNOR = 3'd5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Reserved codes 6 and 7 collapse to AND so the gate mux never sees them.
   function automatic logic [2:0] mode_sanitise(input logic [2:0] m);
      return (m > MODE_XNOR) ? MODE_AND : m;
   endfunction

endpackage

// File: rtl/gate_truth_sweeper_if.sv
// Request/response bundle of the sweeper: start/mode in, vector, gate
// result, handshake flags and the captured truth table out.
interface gate_truth_sweeper_if #(
   parameter int N = 2
);
   logic                start;
   logic [2:0]          mode;
   logic [N-1:0]        vec_out;
   logic                gate_out;
   logic                busy;
   logic                done;
   logic [(1<<N)-1:0]   truth;
   logic                truth_valid;

   modport master (
      output start, mode,
      input  vec_out, gate_out, busy, done, truth, truth_valid
   );

   modport slave (
      input  start, mode,
      output vec_out, gate_out, busy, done, truth, truth_valid
   );
endinterface

// File: rtl/gate_truth_sweeper_gate.sv
// N-input gate built purely from 2-input nand primitives. One reduction
// chain per base function (AND, OR, XOR); the inverted functions reuse the
// chain outputs through a nand-as-inverter, and a mode mux picks the result.
module nand_nway_gate
   import gate_sweep_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] vec_i,
   input  logic [2:0]   mode_i,
   output logic         gate_o
);

   wire [N-1:0] and_c;
   wire [N-1:0] or_c;
   wire [N-1:0] xor_c;
   wire         and_n;
   wire         or_n;
   wire         xor_n;

   assign and_c[0] = vec_i[0];
   assign or_c[0]  = vec_i[0];
   assign xor_c[0] = vec_i[0];

   for (genvar k = 1; k < N; k++) begin : g_stage
      wire a_n, o_pn, o_in, x_t, x_a, x_b;
      // AND: nand followed by nand-inverter
      nand u_a0 (a_n, and_c[k-1], vec_i[k]);
      nand u_a1 (and_c[k], a_n, a_n);
      // OR: nand of the two inverted operands
      nand u_o0 (o_pn, or_c[k-1], or_c[k-1]);
      nand u_o1 (o_in, vec_i[k], vec_i[k]);
      nand u_o2 (or_c[k], o_pn, o_in);
      // XOR: classic four-nand cell
      nand u_x0 (x_t, xor_c[k-1], vec_i[k]);
      nand u_x1 (x_a, xor_c[k-1], x_t);
      nand u_x2 (x_b, vec_i[k], x_t);
      nand u_x3 (xor_c[k], x_a, x_b);
   end

   nand u_an (and_n, and_c[N-1], and_c[N-1]);
   nand u_on (or_n,  or_c[N-1],  or_c[N-1]);
   nand u_xn (xor_n, xor_c[N-1], xor_c[N-1]);

   // Select the chain output for the latched mode
   always_comb begin
      gate_o = and_c[N-1];
      case (mode_i)
         MODE_AND:  gate_o = and_c[N-1];
         MODE_OR:   gate_o = or_c[N-1];
         MODE_NAND: gate_o = and_n;
         MODE_NOR:  gate_o = or_n;
         MODE_XOR:  gate_o = xor_c[N-1];
         MODE_XNOR: gate_o = xor_n;
         default:   gate_o = and_c[N-1];
      endcase
   end

endmodule

// File: rtl/gate_truth_sweeper.sv
// Self-sweeping gate characteriser: steps every N-bit input vector through
// the nand-built gate, holds each for HOLD cycles, captures the result into
// the truth register and signals completion with busy/done/truth_valid.
module gate_truth_sweeper
   import gate_sweep_pkg::*;
#(
   parameter int N    = 2,
   parameter int HOLD = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   gate_truth_sweeper_if.slave    bus
);

   localparam int              HW        = $clog2(HOLD) + 1;
   localparam int              TW        = 1 << N;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N-1:0]    VEC_LAST  = {N{1'b1}};

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  vec_q,   vec_d;
   logic [HW-1:0] hold_q,  hold_d;
   logic [2:0]    mode_q,  mode_d;
   logic [TW-1:0] truth_q, truth_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;
   logic          tv_q,    tv_d;
   logic          gate;

   nand_nway_gate #(.N(N)) u_gate (
      .vec_i  (vec_q),
      .mode_i (mode_q),
      .gate_o (gate)
   );

   // Next-state: accept in IDLE, count/capture/advance in APPLY, pulse in DONE
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      hold_d  = hold_q;
      mode_d  = mode_q;
      truth_d = truth_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      tv_d    = tv_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mode_d  = mode_sanitise(bus.mode);
               vec_d   = '0;
               hold_d  = '0;
               truth_d = '0;
               tv_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            if (hold_q == HOLD_LAST) begin
               truth_d[vec_q] = gate;
               // Terminal compare ends the sweep; the vector never wraps
               if (vec_q == VEC_LAST) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  tv_d    = 1'b1;
               end else begin
                  vec_d  = vec_q + 1'b1;
                  hold_d = '0;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts a sweep and discards the partial table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         hold_q  <= '0;
         mode_q  <= MODE_AND;
         truth_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
         truth_q <= truth_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tv_q    <= tv_d;
      end
   end

   assign bus.vec_out     = vec_q;
   assign bus.gate_out    = gate;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.truth       = truth_q;
   assign bus.truth_valid = tv_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Scoreboard bench: three sweeper instances (N2/H4, N2/H1, N3/H2). Stimulus
// pushes the hand-computed table and completion cycle; per-instance monitors
// pop and compare whenever done is presented.
module tb_gate_truth_sweeper;
   import gate_sweep_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] truth;
      int         done_cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   gate_truth_sweeper_if #(.N(2)) ifa ();
   gate_truth_sweeper_if #(.N(2)) ifb ();
   gate_truth_sweeper_if #(.N(3)) ifc ();

   gate_truth_sweeper #(.N(2), .HOLD(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   gate_truth_sweeper #(.N(2), .HOLD(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   gate_truth_sweeper #(.N(3), .HOLD(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rst(input string nm, input logic [31:0] vec, input logic [31:0] g,
                          input logic [31:0] b, input logic [31:0] d,
                          input logic [31:0] t, input logic [31:0] tv);
      chk({nm, " rst vec_out"}, vec, 32'd0);
      chk({nm, " rst gate_out"}, g, 32'd0);
      chk({nm, " rst busy"}, b, 32'd0);
      chk({nm, " rst done"}, d, 32'd0);
      chk({nm, " rst truth"}, t, 32'd0);
      chk({nm, " rst truth_valid"}, tv, 32'd0);
   endtask

   task automatic score(input string nm, input exp_t e, input logic [7:0] t,
                        input logic tv, input logic b);
      chk({nm, " truth"}, 32'(t), 32'(e.truth));
      chk({nm, " done cycle"}, 32'(cyc), 32'(e.done_cyc));
      chk({nm, " truth_valid at done"}, 32'(tv), 32'd1);
      chk({nm, " busy at done"}, 32'(b), 32'd0);
   endtask

   task automatic unexpected(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected done, got done=1 expected no completion", nm);
   endtask

   // Monitor A: also counts busy cycles per sweep and checks done width
   initial begin : mon_a
      int bcnt;
      logic pd;
      exp_t e;
      bcnt = 0;
      pd = 1'b0;
      forever begin
         @(negedge clk);
         if (ifa.busy) bcnt++;
         if (pd) chk("A done width", 32'(ifa.done), 32'd0);
         pd = ifa.done;
         if (ifa.done) begin
            chk("A busy cycles", 32'(bcnt), 32'd16);
            bcnt = 0;
            if (qa.size() == 0) unexpected("A");
            else begin
               e = qa.pop_front();
               score("A", e, 8'(ifa.truth), ifa.truth_valid, ifa.busy);
            end
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         if (ifb.done) begin
            if (qb.size() == 0) unexpected("B");
            else begin
               e = qb.pop_front();
               score("B", e, 8'(ifb.truth), ifb.truth_valid, ifb.busy);
            end
         end
      end
   end

   initial begin : mon_c
      exp_t e;
      forever begin
         @(negedge clk);
         if (ifc.done) begin
            if (qc.size() == 0) unexpected("C");
            else begin
               e = qc.pop_front();
               score("C", e, ifc.truth, ifc.truth_valid, ifc.busy);
            end
         end
      end
   end

   // Pulse start for one accept edge; optionally register the expectation
   task automatic issue(input int which, input logic [2:0] m, input logic [7:0] t, input bit push);
      int len;
      exp_t e;
      len = (which == 1) ? 4 : 16;
      @(posedge clk);
      #1;
      e = '{truth: t, done_cyc: cyc + 1 + len};
      case (which)
         0: begin ifa.mode = m; ifa.start = 1'b1; if (push) qa.push_back(e); end
         1: begin ifb.mode = m; ifb.start = 1'b1; if (push) qb.push_back(e); end
         default: begin ifc.mode = m; ifc.start = 1'b1; if (push) qc.push_back(e); end
      endcase
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      ifc.start = 1'b0;
   endtask

   task automatic wait_done(input int which, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         case (which)
            0: seen = ifa.done;
            1: seen = ifb.done;
            default: seen = ifc.done;
         endcase
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout dut%0d: got no done expected done within %0d cycles", which, budget);
      end
   endtask

   initial begin : stim
      logic [3:0] nand_tt;
      int c0;
      ifa.start = 1'b0; ifa.mode = MODE_AND;
      ifb.start = 1'b0; ifb.mode = MODE_AND;
      ifc.start = 1'b0; ifc.mode = MODE_AND;
      repeat (2) @(posedge clk);
      #1;
      chk_rst("A", 32'(ifa.vec_out), 32'(ifa.gate_out), 32'(ifa.busy), 32'(ifa.done), 32'(ifa.truth), 32'(ifa.truth_valid));
      chk_rst("B", 32'(ifb.vec_out), 32'(ifb.gate_out), 32'(ifb.busy), 32'(ifb.done), 32'(ifb.truth), 32'(ifb.truth_valid));
      chk_rst("C", 32'(ifc.vec_out), 32'(ifc.gate_out), 32'(ifc.busy), 32'(ifc.done), 32'(ifc.truth), 32'(ifc.truth_valid));
      rst_n = 1'b1;

      // A: OR sweep, busy high right after the accept edge
      issue(0, MODE_OR, 8'h0E, 1'b1);
      chk("A busy after accept", 32'(ifa.busy), 32'd1);
      wait_done(0, 40);

      // A: start held high restarts on the first IDLE cycle after DONE
      @(posedge clk);
      #1;
      c0 = cyc;
      ifa.mode = MODE_OR;
      ifa.start = 1'b1;
      qa.push_back('{truth: 8'h0E, done_cyc: c0 + 17});
      qa.push_back('{truth: 8'h0E, done_cyc: c0 + 35});
      wait_done(0, 40);
      @(posedge clk);
      #1;
      chk("A truth_valid in idle", 32'(ifa.truth_valid), 32'd1);
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      chk("A truth_valid cleared on restart", 32'(ifa.truth_valid), 32'd0);
      chk("A busy on restart", 32'(ifa.busy), 32'd1);
      wait_done(0, 40);

      // B: NAND with HOLD=1, vector advances every cycle
      nand_tt = 4'b0111;
      issue(1, MODE_NAND, 8'h07, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("B vec step", 32'(ifb.vec_out), 32'(i));
         chk("B gate_out", 32'(ifb.gate_out), 32'(nand_tt[i]));
      end
      wait_done(1, 10);
      chk("B vec held at last", 32'(ifb.vec_out), 32'd3);

      // C: N=3 function tables
      issue(2, MODE_XOR, 8'h96, 1'b1);  wait_done(2, 30);
      issue(2, MODE_XNOR, 8'h69, 1'b1); wait_done(2, 30);
      issue(2, 3'd7, 8'h80, 1'b1);      wait_done(2, 30);
      issue(2, MODE_NOR, 8'h01, 1'b1);  wait_done(2, 30);

      // C: start and mode changes mid-sweep are ignored
      issue(2, MODE_OR, 8'hFE, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      ifc.start = 1'b1;
      ifc.mode = MODE_XOR;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      wait_done(2, 30);

      // C: reset in the capture-2 cycle aborts and clears asynchronously
      issue(2, MODE_XOR, 8'h96, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_rst("C abort", 32'(ifc.vec_out), 32'(ifc.gate_out), 32'(ifc.busy), 32'(ifc.done), 32'(ifc.truth), 32'(ifc.truth_valid));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(2, MODE_XOR, 8'h96, 1'b1);
      wait_done(2, 30);

      repeat (3) @(posedge clk);
      chk("A queue drained", 32'(qa.size()), 32'd0);
      chk("B queue drained", 32'(qb.size()), 32'd0);
      chk("C queue drained", 32'(qc.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test expected completion before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
